dg0045_ram_sync: RTL and testbench

- Parametrised successor to the DG0045 64x4 nibble RAM.
- Synchronous single-port RAM with write enable and a registered read port (1-cycle latency).
- Contains a hardware clear sequencer that zeroes every word after reset, with a ready/busy handshake.
- Sits between the DG0045 CPU core and its data memory; the core stalls on ready=0.

---
 rtl/dg0045_pkg.sv | 19 +
 rtl/dg0045_ram_array.sv | 74 +++++++
 rtl/dg0045_ram_sync.sv | 94 +++++++++
 tb/tb_dg0045_ram_sync.sv | 234 +++++++++++++++++++++++
 4 files changed

// File: rtl/dg0045_pkg.sv
// Shared types, default geometry and parity helper for the DG0045 RAM.
// Optional feature macro used by this slice: DG0045_RAM_PARITY_EN.
package dg0045_pkg;

    typedef enum logic {
        ST_CLEAR = 1'b0,
        ST_IDLE  = 1'b1
    } state_e;

    // Legacy 64x4 nibble RAM geometry.
    localparam int unsigned DG0045_DATA_W = 4;
    localparam int unsigned DG0045_ADDR_W = 6;

    // XOR-reduction: the bit that makes the word's one-count even.
    function automatic logic even_parity(input logic [63:0] data);
        return ^data;
    endfunction

endpackage

// File: rtl/dg0045_ram_array.sv
// Storage for dg0045_ram_sync: single port, write-first registered read.
// With DG0045_RAM_PARITY_EN each word carries an even-parity bit and o_par_err is produced.
module dg0045_ram_array
    import dg0045_pkg::*;
#(
    parameter int unsigned DATA_W = DG0045_DATA_W,
    parameter int unsigned ADDR_W = DG0045_ADDR_W
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_we,
    input  logic              i_re,
    input  logic [ADDR_W-1:0] i_addr,
    input  logic [DATA_W-1:0] i_wdata,
`ifdef DG0045_RAM_PARITY_EN
    output logic              o_par_err,
`endif
    output logic [DATA_W-1:0] o_rdata
);

    localparam int unsigned DEPTH = 2 ** ADDR_W;
`ifdef DG0045_RAM_PARITY_EN
    localparam int unsigned WORD_W = DATA_W + 1;
`else
    localparam int unsigned WORD_W = DATA_W;
`endif

    logic [WORD_W-1:0] r_mem [DEPTH];
    logic [WORD_W-1:0] w_wword;
    logic [WORD_W-1:0] w_rword;
    logic [DATA_W-1:0] r_rdata;

    always_comb begin
`ifdef DG0045_RAM_PARITY_EN
        w_wword = {even_parity(64'(i_wdata)), i_wdata};
`else
        w_wword = i_wdata;
`endif
        w_rword = r_mem[i_addr];
    end

    always_ff @(posedge i_clk) begin
        if (i_we) begin
            r_mem[i_addr] <= w_wword;
        end
    end

    // Read port only advances when i_re is set, so it holds across a clear.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_rdata <= '0;
        end else if (i_re) begin
            r_rdata <= i_we ? i_wdata : w_rword[DATA_W-1:0];
        end
    end

    assign o_rdata = r_rdata;

`ifdef DG0045_RAM_PARITY_EN
    logic r_par_err;

    // A word being written is bypassed with fresh parity, so it cannot be in error.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_par_err <= 1'b0;
        end else if (i_re) begin
            r_par_err <= i_we ? 1'b0 : even_parity(64'(w_rword));
        end
    end

    assign o_par_err = r_par_err;
`endif

endmodule

// File: rtl/dg0045_ram_sync.sv
// DG0045 synchronous single-port RAM with a hardware clear sequencer and ready handshake.
// Optional feature macro: DG0045_RAM_PARITY_EN (adds par_err and a parity bit per word).
module dg0045_ram_sync
    import dg0045_pkg::*;
#(
    parameter int unsigned       DATA_W    = DG0045_DATA_W,
    parameter int unsigned       ADDR_W    = DG0045_ADDR_W,
    parameter logic [DATA_W-1:0] CLEAR_VAL = '0
) (
    input  logic              RAM_clk,
    input  logic              RAM_rst,
    input  logic [ADDR_W-1:0] addr,
    input  logic              we,
    input  logic [DATA_W-1:0] din,
    input  logic              clr_req,
`ifdef DG0045_RAM_PARITY_EN
    output logic              par_err,
`endif
    output logic [DATA_W-1:0] dout,
    output logic              ready
);

    state_e            r_state;
    state_e            w_state_d;
    logic [ADDR_W-1:0] r_cnt;
    logic [ADDR_W-1:0] w_cnt_d;

    logic              w_arr_we;
    logic              w_arr_re;
    logic [ADDR_W-1:0] w_arr_addr;
    logic [DATA_W-1:0] w_arr_wdata;

    always_ff @(posedge RAM_clk) begin
        if (RAM_rst) begin
            r_state <= ST_CLEAR;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_d;
            r_cnt   <= w_cnt_d;
        end
    end

    always_comb begin
        w_state_d = r_state;
        w_cnt_d   = r_cnt;
        unique case (r_state)
            ST_CLEAR: begin
                w_cnt_d = r_cnt + ADDR_W'(1);
                if (r_cnt == '1) begin
                    w_state_d = ST_IDLE;
                end
            end
            ST_IDLE: begin
                if (clr_req) begin
                    w_state_d = ST_CLEAR;
                    w_cnt_d   = '0;
                end
            end
        endcase
    end

    // In CLEAR the sequencer owns the array port; user inputs are ignored.
    always_comb begin
        ready       = (r_state == ST_IDLE);
        w_arr_re    = ready;
        w_arr_we    = 1'b0;
        w_arr_addr  = r_cnt;
        w_arr_wdata = CLEAR_VAL;
        if (!RAM_rst) begin
            w_arr_we = ready ? we : 1'b1;
        end
        if (ready) begin
            w_arr_addr  = addr;
            w_arr_wdata = din;
        end
    end

    dg0045_ram_array #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W)
    ) u_array (
        .i_clk     (RAM_clk),
        .i_rst     (RAM_rst),
        .i_we      (w_arr_we),
        .i_re      (w_arr_re),
        .i_addr    (w_arr_addr),
        .i_wdata   (w_arr_wdata),
`ifdef DG0045_RAM_PARITY_EN
        .o_par_err (par_err),
`endif
        .o_rdata   (dout)
    );

endmodule

// File: tb/tb_dg0045_ram_sync.sv
// Self-checking bench for dg0045_ram_sync: behavioural model plus directed and random stimulus.
// Honours DG0045_RAM_PARITY_EN when defined (parity-flip check on the 16x8 instance).
module tb_dg0045_ram_sync;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [5:0] addr = '0;
    logic       we = 1'b0;
    logic [3:0] din = '0;
    logic       clr_req = 1'b0;
    logic [3:0] dout;
    logic       ready;

    logic       b_rst = 1'b1;
    logic [3:0] b_addr = '0;
    logic [7:0] b_dout;
    logic       b_ready;

`ifdef DG0045_RAM_PARITY_EN
    logic par_err;
    logic b_par_err;
`endif

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    dg0045_ram_sync u_dut (
        .RAM_clk (clk),
        .RAM_rst (rst),
        .addr    (addr),
        .we      (we),
        .din     (din),
        .clr_req (clr_req),
`ifdef DG0045_RAM_PARITY_EN
        .par_err (par_err),
`endif
        .dout    (dout),
        .ready   (ready)
    );

    dg0045_ram_sync #(
        .DATA_W    (8),
        .ADDR_W    (4),
        .CLEAR_VAL (8'h55)
    ) u_dut_b (
        .RAM_clk (clk),
        .RAM_rst (b_rst),
        .addr    (b_addr),
        .we      (1'b0),
        .din     (8'h00),
        .clr_req (1'b0),
`ifdef DG0045_RAM_PARITY_EN
        .par_err (b_par_err),
`endif
        .dout    (b_dout),
        .ready   (b_ready)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: memory array, registered read value and number of clear cycles still owed.
    logic [3:0] m_mem [64];
    logic [3:0] m_dout = '0;
    int         m_left = 0;
    bit         m_valid = 0;

    always @(posedge clk) begin
        if (rst) begin
            m_dout  = 4'h0;
            m_left  = 64;
            m_valid = 1;
        end else if (m_left != 0) begin
            m_mem[64 - m_left] = 4'h0;
            m_left--;
        end else begin
            if (we) m_mem[addr] = din;
            m_dout = m_mem[addr];
            if (clr_req) m_left = 64;
        end
    end

    always @(negedge clk) begin
        if (m_valid) begin
            check("model_dout", 32'(dout), 32'(m_dout));
            check("model_ready", 32'(ready), 32'(m_left == 0));
`ifdef DG0045_RAM_PARITY_EN
            check("model_par_err", 32'(par_err), 32'h0);
`endif
        end
    end

    // Counts edges from the current negedge until ready is seen high.
    task automatic count_until_ready(output int n);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!ready && n < 200);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1);
    end

    initial begin
        int n;

        // Power-up clear.
        repeat (2) @(negedge clk);
        check("reset_dout", 32'(dout), 32'h0);
        check("reset_ready", 32'(ready), 32'h0);
        rst = 1'b0;
        count_until_ready(n);
        check("powerup_clear_cycles", 32'(n), 32'd64);
        for (int i = 0; i < 64; i++) begin
            addr = 6'(i);
            @(negedge clk);
            check("powerup_zero", 32'(dout), 32'h0);
        end

        // Write then read back with one-cycle latency; neighbour untouched.
        addr = 6'd5; we = 1'b1; din = 4'hA;
        @(negedge clk);
        we = 1'b0;
        @(negedge clk);
        check("read_addr5", 32'(dout), 32'hA);
        addr = 6'd6;
        @(negedge clk);
        check("read_addr6", 32'(dout), 32'h0);

        // Read during write returns the new data.
        addr = 6'd12; we = 1'b1; din = 4'h3;
        @(negedge clk);
        din = 4'h7;
        @(negedge clk);
        check("write_first", 32'(dout), 32'h7);
        we = 1'b0;

        // Runtime clear with a same-cycle write and a redundant request mid-clear.
        for (int i = 0; i < 64; i++) begin
            addr = 6'(i); we = 1'b1; din = 4'hF;
            @(negedge clk);
        end
        addr = 6'd63; we = 1'b1; din = 4'h1; clr_req = 1'b1;
        @(negedge clk);
        check("clr_dout_write_first", 32'(dout), 32'h1);
        n = 0;
        do begin
            addr = 6'($urandom); we = 1'($urandom); din = 4'($urandom);
            clr_req = (n == 10);
            @(negedge clk);
            n++;
        end while (!ready && n < 200);
        we = 1'b0; clr_req = 1'b0;
        check("runtime_clear_cycles", 32'(n), 32'd64);
        for (int i = 0; i < 64; i++) begin
            addr = 6'(i);
            @(negedge clk);
            check("runtime_clear_zero", 32'(dout), 32'h0);
        end

        // Reset in the middle of a clear restarts it.
        clr_req = 1'b1;
        @(negedge clk);
        clr_req = 1'b0;
        repeat (30) begin
            @(negedge clk);
            check("midclear_dout", 32'(dout), 32'h0);
        end
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        n = 0;
        do begin
            @(negedge clk);
            n++;
            check("midclear_dout", 32'(dout), 32'h0);
        end while (!ready && n < 200);
        check("reset_midclear_cycles", 32'(n), 32'd64);

        // Randomised traffic with occasional clear requests and resets.
        for (int i = 0; i < 1500; i++) begin
            rst     = ($urandom_range(0, 499) == 0);
            clr_req = ($urandom_range(0, 149) == 0);
            we      = 1'($urandom);
            addr    = ($urandom_range(0, 1) == 0) ? 6'($urandom_range(0, 7)) : 6'($urandom);
            din     = 4'($urandom);
            @(negedge clk);
        end
        rst = 1'b0; clr_req = 1'b0; we = 1'b0;
        repeat (70) @(negedge clk);

        // 16x8 instance with a non-zero clear value.
        b_rst = 1'b0;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!b_ready && n < 200);
        check("b_clear_cycles", 32'(n), 32'd16);
        for (int i = 0; i < 16; i++) begin
            b_addr = 4'(i);
            @(negedge clk);
            check("b_clear_val", 32'(b_dout), 32'h55);
`ifdef DG0045_RAM_PARITY_EN
            check("b_par_err_clean", 32'(b_par_err), 32'h0);
`endif
        end

`ifdef DG0045_RAM_PARITY_EN
        u_dut_b.u_array.r_mem[3][8] = ~u_dut_b.u_array.r_mem[3][8];
        b_addr = 4'd3;
        @(negedge clk);
        check("b_par_err_flip", 32'(b_par_err), 32'h1);
        b_addr = 4'd2;
        @(negedge clk);
        check("b_par_err_other", 32'(b_par_err), 32'h0);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
